// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete in the same cycle; misses stall the pipeline around a 128-bit line transfer.
module dcache_ctrl #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 28 - IDX_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p_addr_i,
  input  logic [31:0]  p_data_i,
  input  logic         p_MemRead_i,
  input  logic         p_MemWrite_i,
  output logic [31:0]  p_data_o,
  output logic         p_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [127:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITEBACK   = 2'd1,
    ALLOCATE    = 2'd2,
    REFILL_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic [TAG_W-1:0]   lat_tag_q;
  logic [IDX_W-1:0]   lat_idx_q;

  logic               req, hit, store_hit, fill, latch;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [1:0]         req_off;
  logic               mem_enable_d, mem_write_d;
  logic [31:0]        mem_addr_d;
  logic [127:0]       mem_data_d;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^p_addr_i[1:0];

  assign req_off = p_addr_i[3:2];
  assign req_idx = p_addr_i[4+IDX_W-1:4];
  assign req_tag = p_addr_i[31:4+IDX_W];
  assign req     = p_MemRead_i | p_MemWrite_i;
  assign hit     = valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  assign p_stall_o = req & ~((state_q == IDLE) & hit);
  assign p_data_o  = data_q[req_idx][{req_off, 5'b0} +: 32];

  // Next state and next memory-port values; memory outputs hold unless a state changes them.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_o;
    mem_write_d  = mem_write_o;
    mem_addr_d   = mem_addr_o;
    mem_data_d   = mem_data_o;
    store_hit    = 1'b0;
    fill         = 1'b0;
    latch        = 1'b0;
    case (state_q)
      IDLE: begin
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        if (req) begin
          if (hit) begin
            store_hit = p_MemWrite_i;
          end else begin
            latch        = 1'b1;
            mem_enable_d = 1'b1;
            if (valid_q[req_idx] & dirty_q[req_idx]) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[req_idx], req_idx, 4'b0};
              mem_data_d  = data_q[req_idx];
            end else begin
              state_d     = ALLOCATE;
              mem_write_d = 1'b0;
              mem_addr_d  = {req_tag, req_idx, 4'b0};
            end
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = ALLOCATE;
          mem_write_d = 1'b0;
          mem_addr_d  = {lat_tag_q, lat_idx_q, 4'b0};
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          fill         = 1'b1;
          state_d      = REFILL_DONE;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
        end
      end
      REFILL_DONE: begin
        state_d      = IDLE;
        mem_enable_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, line status bits and registered memory port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      lat_tag_q    <= '0;
      lat_idx_q    <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_o <= mem_enable_d;
      mem_write_o  <= mem_write_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
      if (latch) begin
        lat_tag_q <= req_tag;
        lat_idx_q <= req_idx;
      end
      if (fill) begin
        valid_q[lat_idx_q] <= 1'b1;
        dirty_q[lat_idx_q] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill) begin
        tag_q[lat_idx_q]  <= lat_tag_q;
        data_q[lat_idx_q] <= mem_data_i;
      end else if (store_hit) begin
        data_q[req_idx][{req_off, 5'b0} +: 32] <= p_data_i;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency line memory model.
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p_addr_i;
  logic [31:0]  p_data_i;
  logic         p_MemRead_i;
  logic         p_MemWrite_i;
  logic [31:0]  p_data_o;
  logic         p_stall_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int ntx    = 0;
  int n;
  int ntx_before;
  logic [31:0]  wb_addr = '0;
  logic [31:0]  rd_addr = '0;
  logic [127:0] mem_q [logic [31:0]];
  logic [127:0] wb_line;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p_addr_i     (p_addr_i),
    .p_data_i     (p_data_i),
    .p_MemRead_i  (p_MemRead_i),
    .p_MemWrite_i (p_MemWrite_i),
    .p_data_o     (p_data_o),
    .p_stall_o    (p_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return {32'hC0DE_0000 + a + 32'd3, 32'hC0DE_0000 + a + 32'd2,
            32'hC0DE_0000 + a + 32'd1, 32'hC0DE_0000 + a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; then the memory model answers the L-th cycle of each enabled transaction.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (mem_enable_o) begin
      ecnt++;
      if (ecnt == LAT) begin
        mem_ack_i = 1'b1;
        ntx++;
        ecnt = 0;
        if (mem_write_o) begin
          mem_q[mem_addr_o] = mem_data_o;
          wb_addr = mem_addr_o;
        end else begin
          mem_data_i = line_of(mem_addr_o);
          rd_addr = mem_addr_o;
        end
      end else begin
        mem_ack_i = 1'b0;
      end
    end else begin
      mem_ack_i = 1'b0;
      ecnt = 0;
    end
  endtask

  task automatic run_stall(output int cnt);
    cnt = 0;
    while (p_stall_o && cnt < 50) begin
      cnt++;
      step();
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p_MemRead_i  = rd;
    p_MemWrite_i = wr;
    p_addr_i     = a;
    p_data_i     = d;
    #1;
  endtask

  initial begin
    mem_q[32'h40] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    rst_i = 1'b1;
    p_addr_i = '0; p_data_i = '0; p_MemRead_i = 1'b0; p_MemWrite_i = 1'b0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    chk("rst_enable", 128'(mem_enable_o), 128'd0);
    chk("rst_write", 128'(mem_write_o), 128'd0);
    chk("rst_addr", 128'(mem_addr_o), 128'd0);
    chk("rst_data", mem_data_o, 128'd0);
    chk("rst_stall_idle", 128'(p_stall_o), 128'd0);

    // Cold miss on 0x40
    access(1'b1, 1'b0, 32'h40, 32'h0);
    chk("cold_stall", 128'(p_stall_o), 128'd1);
    run_stall(n);
    chk("cold_penalty", 128'(n), 128'd5);
    chk("cold_rd_addr", 128'(rd_addr), 128'h40);
    chk("cold_data", 128'(p_data_o), 128'h11111111);
    chk("cold_enable_off", 128'(mem_enable_o), 128'd0);

    // Hit on neighbouring word
    access(1'b1, 1'b0, 32'h44, 32'h0);
    chk("hit_stall", 128'(p_stall_o), 128'd0);
    chk("hit_data", 128'(p_data_o), 128'h22222222);
    chk("hit_enable", 128'(mem_enable_o), 128'd0);
    step();

    // Store hit then load back
    ntx_before = ntx;
    access(1'b0, 1'b1, 32'h48, 32'hDEADBEEF);
    chk("st_stall", 128'(p_stall_o), 128'd0);
    step();
    access(1'b1, 1'b0, 32'h48, 32'h0);
    chk("st_ld_data", 128'(p_data_o), 128'hDEADBEEF);
    chk("st_ld_stall", 128'(p_stall_o), 128'd0);
    chk("st_no_traffic", 128'(ntx), 128'(ntx_before));
    step();

    // Conflict miss on dirty line: write-back 0x40 then refill 0x440
    access(1'b1, 1'b0, 32'h448, 32'h0);
    chk("wb_stall", 128'(p_stall_o), 128'd1);
    step();
    chk("wb_enable", 128'(mem_enable_o), 128'd1);
    chk("wb_write", 128'(mem_write_o), 128'd1);
    chk("wb_addr_o", 128'(mem_addr_o), 128'h40);
    wb_line = mem_data_o;
    chk("wb_word2", 128'(wb_line[95:64]), 128'hDEADBEEF);
    run_stall(n);
    chk("wb_penalty", 128'(n + 1), 128'd8);
    chk("wb_mem_addr", 128'(wb_addr), 128'h40);
    chk("refill_addr", 128'(rd_addr), 128'h440);
    chk("wb_data", 128'(p_data_o), 128'hC0DE0442);
    step();

    // Reset during ALLOCATE of 0x80
    access(1'b1, 1'b0, 32'h80, 32'h0);
    step();
    chk("alloc_enable", 128'(mem_enable_o), 128'd1);
    chk("alloc_write", 128'(mem_write_o), 128'd0);
    step();
    rst_i = 1'b1;
    step();
    chk("midrst_enable", 128'(mem_enable_o), 128'd0);
    chk("midrst_stall", 128'(p_stall_o), 128'd1);
    rst_i = 1'b0;
    access(1'b0, 1'b0, 32'h80, 32'h0);
    chk("midrst_idle_stall", 128'(p_stall_o), 128'd0);

    // Reload 0x40 misses again; written-back word must come back
    access(1'b1, 1'b0, 32'h40, 32'h0);
    chk("reload_stall", 128'(p_stall_o), 128'd1);
    run_stall(n);
    chk("reload_penalty", 128'(n), 128'd5);
    chk("reload_data", 128'(p_data_o), 128'h11111111);
    access(1'b1, 1'b0, 32'h48, 32'h0);
    chk("reload_wb_word", 128'(p_data_o), 128'hDEADBEEF);
    step();

    // Read and write together act as a store; output shows the old word
    access(1'b1, 1'b1, 32'h44, 32'h12345678);
    chk("rw_stall", 128'(p_stall_o), 128'd0);
    chk("rw_pre_data", 128'(p_data_o), 128'h22222222);
    step();
    access(1'b1, 1'b0, 32'h44, 32'h0);
    chk("rw_post_data", 128'(p_data_o), 128'h12345678);
    step();

    // Spurious ack in IDLE with no request
    ntx_before = ntx;
    access(1'b0, 1'b0, 32'h40, 32'h0);
    mem_ack_i  = 1'b1;
    mem_data_i = {4{32'hBAD0BAD0}};
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    chk("spur_stall", 128'(p_stall_o), 128'd0);
    chk("spur_enable", 128'(mem_enable_o), 128'd0);
    chk("spur_write", 128'(mem_write_o), 128'd0);
    access(1'b1, 1'b0, 32'h40, 32'h0);
    chk("spur_hit_stall", 128'(p_stall_o), 128'd0);
    chk("spur_data", 128'(p_data_o), 128'h11111111);
    step();
    chk("spur_no_traffic", 128'(ntx), 128'(ntx_before));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and a slower off-chip data memory.
- Replaces the single-cycle Data_Memory path.
- Serves 32-bit word loads and stores from the EX/MEM pipeline register.
- Raises a stall to freeze the whole pipeline while it writes back a dirty line and/or refills from memory over a 128-bit req/ack interface.

Parameters:
IDX_W, 4, index bits; number of lines = 2**IDX_W
TAG_W, 28-IDX_W, tag bits = addr[31:4+IDX_W]

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
p_addr_i  in  32  CPU byte address from EX/MEM ALU result; [1:0] ignored, [3:2] word offset
p_data_i  in  32  CPU store data
p_MemRead_i  in  1  load request
p_MemWrite_i  in  1  store request
p_data_o  out  32  load data; valid only when request active and p_stall_o=0
p_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB
mem_addr_o  out  32  line address, [3:0]=0
mem_data_o  out  128  write-back line data
mem_enable_o  out  1  memory transaction request
mem_write_o  out  1  1=write-back, 0=refill read
mem_data_i  in  128  refill line data, valid with mem_ack_i
mem_ack_i  in  1  one-cycle transaction completion pulse

Behaviour:
- Storage: 2**IDX_W lines, each = valid bit, dirty bit, tag[TAG_W-1:0], data[127:0]. Word w occupies data[32w+31:32w].
- Address split: offset = addr[3:2]; index = addr[4+IDX_W-1:4]; tag = addr[31:4+IDX_W].
- req = p_MemRead_i | p_MemWrite_i. Both asserted together is treated as a store; p_data_o still shows the pre-store word.
- hit = valid[index] & (tag[index] == addr tag).
- p_stall_o is combinational: req & !(state==IDLE & hit). It drops in the same cycle a hit occurs in IDLE.
- p_data_o is combinational: selected word of the indexed line.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL_DONE.
- IDLE, no req: nothing changes.
- IDLE, hit: zero-latency access.
  - Load: p_data_o valid this cycle.
  - Store: at the clock edge, write the word and set dirty.
- IDLE, miss: next state is WRITEBACK if valid[index]&dirty[index], else ALLOCATE.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {victim tag, index, 4'b0}; mem_data_o = victim line.
  - Hold until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 4'b0}.
  - On mem_ack_i: capture mem_data_i into the line; valid=1, dirty=0, tag=req tag; go to REFILL_DONE.
- REFILL_DONE: one cycle, stall held, no memory request; then IDLE.
  - In IDLE the request now hits and completes (a store sets dirty then).
- Memory handshake:
  - mem_enable_o, mem_addr_o and mem_data_o are registered.
  - They stay stable from the first cycle of WRITEBACK/ALLOCATE until the ack cycle inclusive.
  - mem_enable_o deasserts on the cycle after the ack.
  - mem_ack_i is ignored in IDLE and REFILL_DONE.
  - Each transaction takes at least 1 cycle of wait; memory latency is unbounded.
- Miss penalty: clean miss = 1 + L + 1 cycles before the IDLE hit cycle, where L = cycles from enable to ack inclusive. Dirty miss adds L_wb.
- CPU inputs are held stable by the stall. The FSM latches the request tag/index on leaving IDLE and never re-samples mid-miss.
- Reset values:
  - state=IDLE; all valid=0, dirty=0.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - p_stall_o = req (every access misses after reset).
  - Data and tag arrays are not required to clear.
- Reset mid-transaction: abandon immediately. mem_enable_o is low on the cycle after the reset edge. A partially completed write-back is discarded with no refill.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning line {D3,D2,D1,D0}=0x4444..,0x3333..,0x2222..,0x1111.. after L=3 → stall for 5 cycles, mem_addr_o=0x40, mem_write_o=0; the 6th cycle has stall=0 and p_data_o=0x11111111.
- Load 0x44 right after that fill → hit, p_stall_o=0 in the same cycle, p_data_o=0x22222222, mem_enable_o stays 0.
- Store 0xDEADBEEF to 0x48 (hit), then load 0x48 → 0xDEADBEEF with no memory traffic.
- Load 0x448 (same index 4, IDX_W=4, different tag) → write-back first: mem_write_o=1, mem_addr_o=0x40, mem_data_o[95:64]=0xDEADBEEF. After ack, refill from 0x440. Finally the load of 0x448 returns word 2 of the new line.
- Assert rst_i during ALLOCATE → next cycle mem_enable_o=0, state IDLE. Reload of 0x40 misses again (valid cleared).
- Spurious mem_ack_i pulse in IDLE with no req → no state, array, or output change; p_stall_o=0.
